// File: rtl/ctrl_pkg.sv
// Shared constants for the pipeline control blocks: default field widths,
// MDU latencies and the canonical Tnew values producers report.
package ctrl_pkg;

  localparam int ADDR_W_DEF      = 5;
  localparam int T_W_DEF         = 2;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Cycles until a producer's result can be forwarded, by producer kind
  localparam int TNEW_ALU_E  = 1;
  localparam int TNEW_LOAD_E = 2;
  localparam int TNEW_LOAD_M = 1;

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ctrl_stall_md_if.sv
// Decode-side hazard inputs and stall outputs of the stall controller,
// bundled so the core and the bench can hook up with one connection.
interface ctrl_stall_md_if
  import ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int T_W    = T_W_DEF,
  parameter int CNT_W  = 32
);

  logic [T_W-1:0]    Tuse_rs;
  logic [T_W-1:0]    Tuse_rt;
  logic [ADDR_W-1:0] SPL_rs;
  logic [ADDR_W-1:0] SPL_rt;
  logic              GRFWE_E;
  logic              GRFWE_M;
  logic [ADDR_W-1:0] GRF_A3_E;
  logic [ADDR_W-1:0] GRF_A3_M;
  logic [T_W-1:0]    Tnew_E;
  logic [T_W-1:0]    Tnew_M;
  logic              MD_use_D;
  logic              MD_start_E;
  logic              MD_is_div_E;
  logic              IFU_EN_N;
  logic              FR_D_EN_N;
  logic              FR_E_RESET;
  logic              MD_busy;
  logic [CNT_W-1:0]  STALL_CNT;

  modport master (
    output Tuse_rs, Tuse_rt, SPL_rs, SPL_rt, GRFWE_E, GRFWE_M,
           GRF_A3_E, GRF_A3_M, Tnew_E, Tnew_M, MD_use_D, MD_start_E, MD_is_div_E,
    input  IFU_EN_N, FR_D_EN_N, FR_E_RESET, MD_busy, STALL_CNT
  );

  modport slave (
    input  Tuse_rs, Tuse_rt, SPL_rs, SPL_rt, GRFWE_E, GRFWE_M,
           GRF_A3_E, GRF_A3_M, Tnew_E, Tnew_M, MD_use_D, MD_start_E, MD_is_div_E,
    output IFU_EN_N, FR_D_EN_N, FR_E_RESET, MD_busy, STALL_CNT
  );

endinterface

// File: rtl/ctrl_hazard_cmp.sv
// Hazard check for one D-stage source operand: finds the youngest in-flight
// producer of that register and stalls if its value arrives too late.
module ctrl_hazard_cmp
  import ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int T_W    = T_W_DEF
) (
  input  logic [ADDR_W-1:0] i_src,
  input  logic [T_W-1:0]    i_tuse,
  input  logic              i_weE,
  input  logic [ADDR_W-1:0] i_a3E,
  input  logic [T_W-1:0]    i_tnewE,
  input  logic              i_weM,
  input  logic [ADDR_W-1:0] i_a3M,
  input  logic [T_W-1:0]    i_tnewM,
  output logic              o_stall
);

  logic w_hitE;
  logic w_hitM;

  // $0 never carries a dependency; the E producer is younger and hides M
  assign w_hitE  = (i_src != '0) && i_weE && (i_src == i_a3E);
  assign w_hitM  = (i_src != '0) && i_weM && (i_src == i_a3M) && !w_hitE;
  assign o_stall = (w_hitE && (i_tuse < i_tnewE)) || (w_hitM && (i_tuse < i_tnewM));

endmodule

// File: rtl/ctrl_stall_md.sv
// Decode-stage stall controller: register hazards from Tuse/Tnew, MDU busy
// tracking and a saturating count of stalled cycles.
module ctrl_stall_md
  import ctrl_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int T_W         = T_W_DEF,
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  ctrl_stall_md_if.slave   bus
);

  localparam int MD_MAX = maxOf(MULT_CYCLES, DIV_CYCLES);
  localparam int MD_W   = $clog2(MD_MAX + 1);

  logic [MD_W-1:0]  r_mdCnt;
  logic [CNT_W-1:0] r_stallCnt;
  logic             w_stallRs;
  logic             w_stallRt;
  logic             w_mdBusy;
  logic             w_mdStall;
  logic             w_stall;

  ctrl_hazard_cmp #(.ADDR_W(ADDR_W), .T_W(T_W)) uRsCmp (
    .i_src  (bus.SPL_rs),
    .i_tuse (bus.Tuse_rs),
    .i_weE  (bus.GRFWE_E),
    .i_a3E  (bus.GRF_A3_E),
    .i_tnewE(bus.Tnew_E),
    .i_weM  (bus.GRFWE_M),
    .i_a3M  (bus.GRF_A3_M),
    .i_tnewM(bus.Tnew_M),
    .o_stall(w_stallRs)
  );

  ctrl_hazard_cmp #(.ADDR_W(ADDR_W), .T_W(T_W)) uRtCmp (
    .i_src  (bus.SPL_rt),
    .i_tuse (bus.Tuse_rt),
    .i_weE  (bus.GRFWE_E),
    .i_a3E  (bus.GRF_A3_E),
    .i_tnewE(bus.Tnew_E),
    .i_weM  (bus.GRFWE_M),
    .i_a3M  (bus.GRF_A3_M),
    .i_tnewM(bus.Tnew_M),
    .o_stall(w_stallRt)
  );

  // A start in E counts as busy already, so an MDU op right behind it waits
  assign w_mdBusy  = (r_mdCnt != '0);
  assign w_mdStall = bus.MD_use_D && (w_mdBusy || bus.MD_start_E);
  assign w_stall   = w_stallRs || w_stallRt || w_mdStall;

  assign bus.IFU_EN_N   = w_stall;
  assign bus.FR_D_EN_N  = w_stall;
  assign bus.FR_E_RESET = w_stall;
  assign bus.MD_busy    = w_mdBusy;
  assign bus.STALL_CNT  = r_stallCnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mdCnt <= '0;
    end else if (bus.MD_start_E) begin
      r_mdCnt <= bus.MD_is_div_E ? MD_W'(DIV_CYCLES) : MD_W'(MULT_CYCLES);
    end else if (r_mdCnt != '0) begin
      r_mdCnt <= r_mdCnt - MD_W'(1);
    end
  end

  // Holds at all-ones so a long run never reads back as a small count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stallCnt <= '0;
    end else if (w_stall && (r_stallCnt != '1)) begin
      r_stallCnt <= r_stallCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ctrl_stall_md.sv
// Bench for ctrl_stall_md: directed hazard/MDU/counter cases followed by
// random traffic, all compared against a cycle-level reference model.
module tb_ctrl_stall_md;
  import ctrl_pkg::*;

  localparam int ADDR_W  = ADDR_W_DEF;
  localparam int T_W     = T_W_DEF;
  localparam int MULT    = MULT_CYCLES_DEF;
  localparam int DIV     = DIV_CYCLES_DEF;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic reset_n;

  int checkCount;
  int passCount;
  int busyLeft;
  int stallCnt;

  ctrl_stall_md_if #(.ADDR_W(ADDR_W), .T_W(T_W), .CNT_W(CNT_W)) bus ();

  ctrl_stall_md #(
    .ADDR_W(ADDR_W), .T_W(T_W), .MULT_CYCLES(MULT), .DIV_CYCLES(DIV), .CNT_W(CNT_W)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  // A source waits on the youngest producer of its register, if any
  function automatic logic operandStall(input logic [ADDR_W-1:0] src, input logic [T_W-1:0] tuse);
    if (src == 0) return 1'b0;
    if (bus.GRFWE_E && bus.GRF_A3_E == src) return int'(tuse) < int'(bus.Tnew_E);
    if (bus.GRFWE_M && bus.GRF_A3_M == src) return int'(tuse) < int'(bus.Tnew_M);
    return 1'b0;
  endfunction

  function automatic logic modelStall();
    logic mdWait;
    mdWait = bus.MD_use_D && ((busyLeft > 0) || bus.MD_start_E);
    return operandStall(bus.SPL_rs, bus.Tuse_rs) || operandStall(bus.SPL_rt, bus.Tuse_rt) || mdWait;
  endfunction

  task automatic applyStimulus(input logic [ADDR_W-1:0] rs, input logic [T_W-1:0] tuseRs,
                               input logic [ADDR_W-1:0] rt, input logic [T_W-1:0] tuseRt,
                               input logic weE, input logic [ADDR_W-1:0] a3E, input logic [T_W-1:0] tnewE,
                               input logic weM, input logic [ADDR_W-1:0] a3M, input logic [T_W-1:0] tnewM,
                               input logic useD, input logic start, input logic isDiv);
    bus.SPL_rs = rs;   bus.Tuse_rs = tuseRs;
    bus.SPL_rt = rt;   bus.Tuse_rt = tuseRt;
    bus.GRFWE_E = weE; bus.GRF_A3_E = a3E; bus.Tnew_E = tnewE;
    bus.GRFWE_M = weM; bus.GRF_A3_M = a3M; bus.Tnew_M = tnewM;
    bus.MD_use_D = useD; bus.MD_start_E = start; bus.MD_is_div_E = isDiv;
  endtask

  // One cycle: compare at the falling edge, then advance the model on the rising edge
  task automatic runCycle(input string tag, input int expS);
    logic s;
    @(negedge clk);
    s = modelStall();
    assert (!(bus.MD_start_E && bus.MD_busy)) else $error("[TB] MDU start issued while busy");
    if (expS >= 0) checkOutput({tag, ".Sdirect"}, 32'(bus.IFU_EN_N), 32'(expS));
    checkOutput({tag, ".IFU"},  32'(bus.IFU_EN_N),   32'(s));
    checkOutput({tag, ".FRD"},  32'(bus.FR_D_EN_N),  32'(s));
    checkOutput({tag, ".FRE"},  32'(bus.FR_E_RESET), 32'(s));
    checkOutput({tag, ".busy"}, 32'(bus.MD_busy),    32'(busyLeft > 0));
    checkOutput({tag, ".cnt"},  32'(bus.STALL_CNT),  32'(stallCnt));
    @(posedge clk);
    if (s && stallCnt < CNT_MAX) stallCnt++;
    if (bus.MD_start_E) busyLeft = bus.MD_is_div_E ? DIV : MULT;
    else if (busyLeft > 0) busyLeft--;
    #1;
  endtask

  // Asynchronous reset pulse placed mid-cycle, well away from either clock edge
  task automatic doReset(input string tag);
    reset_n = 1'b0;
    #1;
    busyLeft = 0;
    stallCnt = 0;
    checkOutput({tag, ".busy"}, 32'(bus.MD_busy),   32'd0);
    checkOutput({tag, ".cnt"},  32'(bus.STALL_CNT), 32'd0);
    checkOutput({tag, ".S"},    32'(bus.IFU_EN_N),  32'(modelStall()));
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checkCount = 0;
    passCount  = 0;
    busyLeft   = 0;
    stallCnt   = 0;
    reset_n    = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    doReset("reset");

    applyStimulus(8, 1, 0, 0, 1, 8, T_W'(TNEW_LOAD_E), 0, 0, 0, 0, 0, 0);
    runCycle("loaduseE", 1);
    applyStimulus(8, 1, 0, 0, 0, 0, 0, 1, 8, T_W'(TNEW_LOAD_M), 0, 0, 0);
    runCycle("loaduseM", 0);
    applyStimulus(0, 0, 9, 1, 1, 9, T_W'(TNEW_ALU_E), 0, 0, 0, 0, 0, 0);
    runCycle("aluTuse1", 0);
    applyStimulus(0, 0, 9, 0, 1, 9, T_W'(TNEW_ALU_E), 0, 0, 0, 0, 0, 0);
    runCycle("aluTuse0", 1);

    applyStimulus(0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 0, 0, 0);
    runCycle("zeroReg", 0);
    applyStimulus(5, 0, 0, 0, 1, 5, 0, 1, 5, 1, 0, 0, 0);
    runCycle("shadow", 0);

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    runCycle("mult0", 1);
    bus.MD_start_E = 1'b0;
    for (int c = 1; c <= MULT; c++) runCycle($sformatf("mult%0d", c), 1);
    runCycle("multDone", 0);

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    runCycle("div0", 1);
    bus.MD_start_E = 1'b0;
    for (int c = 1; c < 4; c++) runCycle($sformatf("div%0d", c), 1);
    doReset("divReset");
    runCycle("divAfterReset", 0);

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    runCycle("combStart", 0);
    applyStimulus(8, 1, 0, 0, 1, 8, 2, 0, 0, 0, 1, 0, 0);
    for (int c = 0; c < 3; c++) runCycle($sformatf("comb%0d", c), 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) runCycle("drain", 0);

    applyStimulus(8, 1, 0, 0, 1, 8, 2, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 20; c++) runCycle("perf", 1);
    checkOutput("perfSaturated", 32'(bus.STALL_CNT), 32'(CNT_MAX));

    for (int i = 0; i < 400; i++) begin
      logic start;
      if (i % 60 == 59) doReset("rndReset");
      start = (busyLeft == 0) && ($urandom_range(3) == 0);
      applyStimulus(ADDR_W'($urandom_range(3)), T_W'($urandom_range(3)),
                    ADDR_W'($urandom_range(3)), T_W'($urandom_range(3)),
                    1'($urandom_range(1)), ADDR_W'($urandom_range(3)), T_W'($urandom_range(3)),
                    1'($urandom_range(1)), ADDR_W'($urandom_range(3)), T_W'($urandom_range(3)),
                    1'($urandom_range(1)), start, 1'($urandom_range(1)));
      runCycle("rnd", -1);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
